// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master/slave drivers.
//   spi_state_t     : slave frame FSM states (IDLE / LOAD / SHIFT)
//   SPI_FRAME_BITS  : bits per SPI frame
//   SPI_CNT_W       : width of a bit counter spanning one frame
//   SPI_LAST_BIT    : counter value of the final bit of a frame
//   SPI_IDLE_BYTE   : default fill byte when no data is pending
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    localparam int SPI_FRAME_BITS = 8;
    localparam int SPI_CNT_W      = $clog2(SPI_FRAME_BITS);
    localparam logic [SPI_CNT_W-1:0] SPI_LAST_BIT = SPI_CNT_W'(SPI_FRAME_BITS - 1);

    localparam logic [SPI_FRAME_BITS-1:0] SPI_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// STAGES-deep synchronizer for an asynchronous pin, followed by a one-cycle
// delayed copy used for edge detection. STAGES = 0 bypasses the synchronizer
// (only legal when the pin is generated on clk).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset (all flops cleared)
//   din  : raw pin
//   sync : synchronized level
//   rise : one-cycle pulse on a 0->1 transition of sync
//   fall : one-cycle pulse on a 1->0 transition of sync
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic prev;

    generate
        if (STAGES == 0) begin : g_bypass
            assign sync = din;
        end else begin : g_sync
            logic [STAGES-1:0] chain;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chain <= '0;
                end else begin
                    chain[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign sync = chain[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_driver.sv
// -----------------------------------------------------------------------------
// spi_slave_driver
// SPI slave, CPOL=0 / CPHA=0, LSB first, 8-bit frames, back-to-back bytes
// allowed within one CS assertion. SCLK/CS/MOSI are oversampled on clk_i.
//
// Bus-side handshake: tx_load_i is a one-cycle strobe that writes tx_data_bi
// into a single holding register (overwriting any unconsumed byte);
// tx_pending_o stays high until a frame start or byte boundary consumes it.
// rx_valid_o pulses for one cycle when rx_data_bo updates; the byte counts as
// unread until rx_ack_i. A new byte arriving while unread sets the sticky
// rx_overrun_o, which rx_ack_i clears.
//
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   tx_data_bi, tx_load_i : byte to send next, load strobe
//   tx_pending_o          : holding register full
//   rx_data_bo            : last complete received byte
//   rx_valid_o            : one-cycle pulse when rx_data_bo updates
//   rx_overrun_o          : sticky overrun flag
//   rx_ack_i              : system has read rx_data_bo
//   busy_o                : frame in progress
//   frame_abort_o         : one-cycle pulse, CS released mid-byte
//   spi_cs_i/sclk_i/mosi_i: SPI pins from master
//   spi_miso_o            : SPI data to master, 0 while deselected
//   state_o               : current FSM state (debug)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_slave_driver
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_bi,
    input  logic       tx_load_i,
    output logic       tx_pending_o,
    output logic [7:0] rx_data_bo,
    output logic       rx_valid_o,
    output logic       rx_overrun_o,
    input  logic       rx_ack_i,
    output logic       busy_o,
    output logic       frame_abort_o,
    input  logic       spi_cs_i,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output spi_state_t state_o
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    spi_state_t state, state_next;

    logic [7:0]           hold, tx_shift, rx_shift, rx_data, reload_byte, rx_next;
    logic [SPI_CNT_W-1:0] cnt;
    logic                 pending, miso, rx_valid, overrun, unread, abort, started;
    logic                 reload, shift_tx, shift_rx, complete, end_frame, abort_now;
    logic                 unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (spi_sclk_i),
        .sync (sclk_sync),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (spi_cs_i),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (spi_mosi_i),
        .sync (mosi_sync),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    // Only edges of CS are used, and only the level of MOSI.
    assign unused_sync = ^{cs_sync, mosi_rise, mosi_fall, sclk_sync};

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        reload     = 1'b0;
        shift_tx   = 1'b0;
        shift_rx   = 1'b0;
        end_frame  = 1'b0;
        case (state)
            ST_IDLE: begin
                // SCLK activity while deselected is ignored here.
                if (cs_fall) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                    end_frame  = 1'b1;
                end else begin
                    state_next = ST_SHIFT;
                    reload     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                    end_frame  = 1'b1;
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                end else if (sclk_fall) begin
                    // A fall at count 0 follows the last bit of a byte: fetch
                    // the next byte so bit0 is ready before the next rise.
                    if (cnt == '0) begin
                        reload = 1'b1;
                    end else begin
                        shift_tx = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign complete    = shift_rx && (cnt == SPI_LAST_BIT);
    assign abort_now   = end_frame && (cnt != '0);
    assign reload_byte = pending ? hold : IDLE_BYTE;
    assign rx_next     = {mosi_sync, rx_shift[7:1]};

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold     <= '0;
            pending  <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            cnt      <= '0;
            started  <= 1'b0;
            miso     <= 1'b0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            unread   <= 1'b0;
            abort    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            abort    <= abort_now;

            // A load coinciding with a reload keeps the new byte pending;
            // the reload itself already sampled the old holding value.
            if (tx_load_i) begin
                hold    <= tx_data_bi;
                pending <= 1'b1;
            end else if (reload) begin
                pending <= 1'b0;
            end

            if (reload) begin
                tx_shift <= reload_byte;
                miso     <= reload_byte[0];
            end else if (shift_tx) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                miso     <= tx_shift[1];
            end else if (end_frame) begin
                miso <= 1'b0;
            end

            // Partial rx bits are dropped by clearing the count at frame end.
            if (end_frame || state == ST_LOAD) begin
                cnt     <= '0;
                started <= 1'b0;
            end else if (shift_rx) begin
                cnt      <= cnt + 1'b1;
                started  <= 1'b1;
                rx_shift <= rx_next;
            end

            // New byte wins over a same-cycle acknowledge.
            if (complete) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                unread   <= 1'b1;
                if (unread) begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack_i) begin
                unread  <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    assign tx_pending_o  = pending;
    assign rx_data_bo    = rx_data;
    assign rx_valid_o    = rx_valid;
    assign rx_overrun_o  = overrun;
    assign frame_abort_o = abort;
    assign spi_miso_o    = miso;
    assign state_o       = state;
    assign busy_o        = (state == ST_LOAD) ||
                           ((state == ST_SHIFT) && ((cnt != '0) || !started));

endmodule

// File: tb/tb_spi_slave_driver.sv
`timescale 1ns/1ps
module tb_spi_slave_driver;
    import spi_pkg::*;

    localparam int HALF  = 4;   // SCLK half-period in clk cycles
    localparam int SETUP = 6;   // CS-low to first SCLK rise

    // ------------------------------------------------ clock / reset / DUT
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_load = 1'b0;
    logic       rx_ack = 1'b0;
    logic       cs = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       tx_pending, rx_valid, rx_overrun, busy, frame_abort, miso;
    logic [7:0] rx_data;
    spi_state_t dbg_state;

    always #5 clk = ~clk;

    spi_slave_driver #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tx_data_bi    (tx_data),
        .tx_load_i     (tx_load),
        .tx_pending_o  (tx_pending),
        .rx_data_bo    (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_overrun_o  (rx_overrun),
        .rx_ack_i      (rx_ack),
        .busy_o        (busy),
        .frame_abort_o (frame_abort),
        .spi_cs_i      (cs),
        .spi_sclk_i    (sclk),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .state_o       (dbg_state)
    );

    // ------------------------------------------------------- scoreboard
    int         checks = 0;
    int         errors = 0;
    int         abort_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_abort) abort_cnt++;
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_valid_unexpected: got pulse with data 0x%0h expected no pulse", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_data_at_valid", {24'h0, rx_data}, {24'h0, mon_exp});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------------------------------------------------- drivers
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(SETUP);
    endtask

    task automatic cs_high();
        tick(HALF);
        cs = 1'b1;
        tick(8);
    endtask

    // Mode 0 master: data changes while SCLK low, MISO sampled before rise.
    task automatic xfer(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
        miso_b = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mosi_b[i];
            tick(HALF);
            miso_b[i] = miso;
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_miso"},    {31'h0, miso},        32'h0);
        check({tag, "_busy"},    {31'h0, busy},        32'h0);
        check({tag, "_pending"}, {31'h0, tx_pending},  32'h0);
        check({tag, "_overrun"}, {31'h0, rx_overrun},  32'h0);
        check({tag, "_valid"},   {31'h0, rx_valid},    32'h0);
        check({tag, "_abort"},   {31'h0, frame_abort}, 32'h0);
        check({tag, "_state"},   32'(dbg_state),       32'(ST_IDLE));
    endtask

    // -------------------------------------------------------- vectors
    typedef struct {
        logic       load;
        logic [7:0] tx;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] got, got2;
    int         abort_before;

    initial begin
        vecs[0] = '{load: 1'b1, tx: 8'h3C, mosi_b: 8'hA5, exp_miso: 8'h3C};
        vecs[1] = '{load: 1'b0, tx: 8'h00, mosi_b: 8'hFF, exp_miso: 8'h00};
        vecs[2] = '{load: 1'b1, tx: 8'hC3, mosi_b: 8'h0F, exp_miso: 8'hC3};
        vecs[3] = '{load: 1'b1, tx: 8'h80, mosi_b: 8'h01, exp_miso: 8'h80};
        vecs[4] = '{load: 1'b1, tx: 8'hFF, mosi_b: 8'h00, exp_miso: 8'hFF};

        // Reset state
        tick(3);
        check_idle_outputs("reset");
        check("reset_rx_data", {24'h0, rx_data}, 32'h0);
        rst = 1'b0;
        tick(5);
        check_idle_outputs("post_reset");

        // Single-byte frames from the table
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].load) begin
                load_tx(vecs[v].tx);
                check($sformatf("v%0d_pending_after_load", v), {31'h0, tx_pending}, 32'h1);
            end
            exp_q.push_back(vecs[v].mosi_b);
            cs_low();
            check($sformatf("v%0d_busy_before_first_rise", v), {31'h0, busy}, 32'h1);
            xfer(vecs[v].mosi_b, 8, got);
            cs_high();
            check($sformatf("v%0d_miso_byte", v), {24'h0, got}, {24'h0, vecs[v].exp_miso});
            check($sformatf("v%0d_rx_data", v), {24'h0, rx_data}, {24'h0, vecs[v].mosi_b});
            check($sformatf("v%0d_overrun", v), {31'h0, rx_overrun}, 32'h0);
            check($sformatf("v%0d_pending", v), {31'h0, tx_pending}, 32'h0);
            check($sformatf("v%0d_miso_idle", v), {31'h0, miso}, 32'h0);
            ack();
        end

        // Two bytes under one CS; second byte loaded after frame start
        load_tx(8'h11);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h42);
        cs_low();
        check("b2b_pending_consumed", {31'h0, tx_pending}, 32'h0);
        load_tx(8'h22);
        check("b2b_pending_second", {31'h0, tx_pending}, 32'h1);
        xfer(8'h81, 8, got);
        check("b2b_busy_at_boundary", {31'h0, busy}, 32'h0);
        xfer(8'h42, 8, got2);
        cs_high();
        check("b2b_miso_first", {24'h0, got}, 32'h11);
        check("b2b_miso_second", {24'h0, got2}, 32'h22);
        check("b2b_rx_data", {24'h0, rx_data}, 32'h42);
        check("b2b_overrun_set", {31'h0, rx_overrun}, 32'h1);
        check("b2b_pending_end", {31'h0, tx_pending}, 32'h0);
        ack();
        check("b2b_overrun_cleared", {31'h0, rx_overrun}, 32'h0);

        // CS released after 3 bits
        abort_before = abort_cnt;
        cs_low();
        xfer(8'hFF, 3, got);
        check("abort_busy_mid", {31'h0, busy}, 32'h1);
        cs_high();
        check("abort_pulse", abort_cnt, abort_before + 1);
        check("abort_rx_data_kept", {24'h0, rx_data}, 32'h42);
        check("abort_miso", {31'h0, miso}, 32'h0);
        check("abort_busy_after", {31'h0, busy}, 32'h0);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));

        // Two frames without acknowledge
        exp_q.push_back(8'h33);
        cs_low();
        xfer(8'h33, 8, got);
        cs_high();
        check("ovr_first_clear", {31'h0, rx_overrun}, 32'h0);
        exp_q.push_back(8'h44);
        cs_low();
        xfer(8'h44, 8, got);
        cs_high();
        check("ovr_set", {31'h0, rx_overrun}, 32'h1);
        check("ovr_rx_data", {24'h0, rx_data}, 32'h44);
        ack();
        check("ovr_cleared", {31'h0, rx_overrun}, 32'h0);

        // Reset after 5 bits, with a byte left pending
        load_tx(8'h77);
        cs_low();
        load_tx(8'h99);
        xfer(8'hC6, 5, got);
        rst = 1'b1;
        tick(2);
        check_idle_outputs("midrst");
        check("midrst_rx_data", {24'h0, rx_data}, 32'h0);
        rst = 1'b0;
        tick(1);
        xfer(8'hC6, 3, got);
        cs_high();
        check("midrst_no_abort", abort_cnt, abort_before + 1);
        check("midrst_rx_data_after", {24'h0, rx_data}, 32'h0);
        exp_q.push_back(8'h5A);
        cs_low();
        xfer(8'h5A, 8, got);
        cs_high();
        check("post_rst_rx_data", {24'h0, rx_data}, 32'h5A);
        check("post_rst_miso_idle_byte", {24'h0, got}, 32'h00);

        check("exp_q_drained", exp_q.size(), 32'h0);
        check("abort_total", abort_cnt, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_driver.md
Name: spi_slave_driver

Overview:
SPI slave controller, CPOL=0/CPHA=0, LSB-first, 8-bit frames. It is the counterpart of the team's SPI master driver.
- Oversamples SCLK/CS/MOSI on clk_i and shifts in MOSI.
- Shifts out a byte preloaded by the system side on MISO.
- Sits between an SPI pin group and a simple register/bus-side interface. Supports back-to-back bytes within one CS assertion.

Parameters:
SYNC_STAGES, 2, synchronizer depth on spi_sclk_i/spi_cs_i/spi_mosi_i. 0 = bypass, legal only when the master runs on clk_i.
IDLE_BYTE, 8'h00, byte shifted out when no TX byte is pending at frame start.

Ports:
clk_i  in  1  system clock; all logic on posedge
rst_i  in  1  synchronous, active-high reset
tx_data_bi  in  8  byte to transmit on next frame
tx_load_i  in  1  one-cycle strobe; captures tx_data_bi into holding register
tx_pending_o  out  1  holding register full, not yet consumed
rx_data_bo  out  8  last complete byte received
rx_valid_o  out  1  one-cycle pulse when rx_data_bo updates
rx_overrun_o  out  1  sticky; set if rx_valid fires while previous byte unread; cleared by rx_ack_i
rx_ack_i  in  1  system has read rx_data_bo
busy_o  out  1  CS active (low) and mid-frame
frame_abort_o  out  1  one-cycle pulse: CS deasserted with 1..7 bits shifted
spi_cs_i  in  1  chip select, active low
spi_sclk_i  in  1  serial clock from master
spi_mosi_i  in  1  master-out data
spi_miso_o  out  1  slave-out data; 0 while CS high

Behaviour:
- Reset: all outputs 0, bit counter 0, shift regs 0, holding register empty, FSM=IDLE.
- Sync: SCLK/CS/MOSI pass through SYNC_STAGES flops. Edge detect compares the synchronized value with a one-cycle-delayed copy.
- Timing requirement: SCLK half-period ≥ SYNC_STAGES+2 clk_i cycles. With SYNC_STAGES=0, the 2-cycle half-period of the team's master is supported.
- FSM states:
  - IDLE (CS high).
  - LOAD (CS low seen; 1 cycle).
  - SHIFT.
- IDLE→LOAD on synchronized CS falling edge.
- LOAD:
  - tx shift reg := holding reg if pending, else IDLE_BYTE; pending cleared.
  - spi_miso_o := bit0 (valid before first rising SCLK, as mode 0 requires).
  - counter := 0; then → SHIFT.
- SHIFT, SCLK rising edge: rx_shift := {mosi, rx_shift[7:1]}; counter++.
  - On 8th rise: rx_data_bo := new value, rx_valid_o pulses the next cycle, counter := 0.
  - If rx_valid fires while no rx_ack_i was seen since the last pulse, rx_overrun_o sets.
- SHIFT, SCLK falling edge:
  - If counter≠0: tx shift right, spi_miso_o := next bit.
  - If counter==0 (byte boundary): reload tx from holding/IDLE_BYTE as in LOAD, then drive bit0. This makes back-to-back frames seamless.
- CS rising edge in SHIFT → IDLE, spi_miso_o := 0.
  - If counter in 1..7: frame_abort_o pulses and partial rx data is discarded (rx_data_bo unchanged).
  - If counter==0: no abort.
- busy_o = 1 in LOAD/SHIFT while counter≠0, or while CS is low before the first rise.
- tx_load_i while pending=1: overwrites holding register.
- tx_load_i in the same cycle as a LOAD/boundary reload: the reload takes the old holding value (or IDLE_BYTE). The new byte then stays pending.
- rx_ack_i and a new rx_valid in the same cycle: overrun sets (the new byte wins).
- SCLK edges while CS high are ignored.
- rst_i mid-frame: immediate return to reset state. The remaining frame is ignored until the next CS falling edge.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state localparams (IDLE/LOAD/SHIFT).
  - SPI_FRAME_BITS=8.
  - A default IDLE_BYTE constant, also used by the master for fill bytes.
- One natural sub-module: spi_sync_edge. It is a SYNC_STAGES-deep synchronizer with rise/fall pulse outputs, instantiated for SCLK and CS; MOSI uses the data path only.

Test Plan:
- Paired with the team's master on clk_i, SYNC_STAGES=0: tx_load 0x3C, master sends 0xA5 → slave rx_data_bo=0xA5 with one rx_valid pulse; master data_out_bo=0x3C.
- No tx_load before frame, IDLE_BYTE=0x00: master sends 0xFF → master receives 0x00, rx_data_bo=0xFF.
- Two bytes under one CS, tx bytes 0x11 then 0x22 (second loaded mid-first-frame) → master receives 0x11 then 0x22. Slave rx pulses twice with 0x81, 0x42 as sent.
- Model-driven SCLK, SYNC_STAGES=2, half-period 4: CS rises after 3 bits → frame_abort_o pulse, no rx_valid, rx_data_bo unchanged, spi_miso_o=0.
- Two frames, no rx_ack_i between → rx_overrun_o=1 after second rx_valid. rx_ack_i clears it.
- rst_i asserted after 5 bits → all outputs 0. Next full frame 0x5A is received correctly.
